// File: rtl/apb_req_master_if.sv
// Command/response handshake plus APB requester signals for apb_req_master.
// The master modport is the bridge itself; the slave modport is its surroundings (client and completer).
interface apb_req_master_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [APB_ADDR_WIDTH-1:0] req_addr;
  logic [31:0]               req_wdata;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [31:0]               rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;

  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_req_master.sv
// Single-outstanding command-to-APB bridge: one request in, one APB transfer out,
// one response back, with optional abort after a bounded number of wait states.
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  apb_req_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Counter value seen during the last permitted ACCESS cycle.
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      tmo_q, tmo_d;
  logic [15:0]               wait_cnt_q, wait_cnt_d;
  logic                      cmd_aligned;

  assign cmd_aligned = (bus.req_addr[1:0] == 2'b00);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (cmd_aligned) begin
            paddr_d  = bus.req_addr;
            pwdata_d = bus.req_wdata;
            pwrite_d = bus.req_write;
            state_d  = SETUP;
          end else begin
            // Misaligned commands never reach the bus; fail them straight away.
            rdata_d = '0;
            err_d   = 1'b1;
            tmo_d   = 1'b0;
            state_d = RESP;
          end
        end
      end
      SETUP: begin
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        // A completer answering in the final permitted cycle still wins over the abort.
        if (bus.PREADY) begin
          err_d   = bus.PSLVERR;
          tmo_d   = 1'b0;
          rdata_d = pwrite_q ? 32'h0 : bus.PRDATA;
          state_d = RESP;
        end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    bus.PENABLE   = (state_q == ACCESS);
  end

  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Randomised scoreboard bench for apb_req_master with an APB completer model
// and a transaction-level reference for response contents and latency.
module tb_apb_req_master;

  localparam int AW  = 12;
  localparam int TMO = 4;

  logic HCLK;
  logic HRESETn;
  int   cyc;
  int   checks;
  int   errors;
  int   hold_req;

  apb_req_master_if #(.APB_ADDR_WIDTH(AW)) bus ();

  apb_req_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.master)
  );

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          tmo;
    int          lat;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    bit            wr;
    int            waits;
    logic [31:0]   rdata;
    bit            slverr;
    int            pen;
  } plan_t;

  exp_t  sb_q[$];
  plan_t cpl_q[$];

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: outcome of one command from its address, completer wait states and the timeout limit.
  function automatic void model(input bit wr, input logic [AW-1:0] addr, input int waits,
                                input logic [31:0] rd, input bit slverr,
                                output exp_t e, output int pen);
    e.acc_cyc = 0;
    if (addr[1:0] != 2'b00) begin
      e.rdata = 0; e.err = 1; e.tmo = 0; e.lat = 1; pen = 0;
    end else if (TMO != 0 && waits >= TMO) begin
      e.rdata = 0; e.err = 1; e.tmo = 1; pen = TMO; e.lat = 2 + TMO;
    end else begin
      pen = waits + 1;
      e.rdata = wr ? 32'h0 : rd; e.err = slverr; e.tmo = 0; e.lat = 2 + pen;
    end
  endfunction

  task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                       input int waits, input logic [31:0] rd, input bit slverr, input bit no_rsp);
    exp_t  e;
    plan_t p;
    int    pen;
    int    n;
    model(wr, addr, waits, rd, slverr, e, pen);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!bus.req_ready && n < 200);
    chk("req_accept", {31'h0, bus.req_ready}, 32'h1);
    if (bus.req_ready) begin
      e.acc_cyc = cyc;
      if (!no_rsp) sb_q.push_back(e);
      if (addr[1:0] == 2'b00) begin
        p.addr = addr; p.wdata = wd; p.wr = wr; p.waits = waits;
        p.rdata = rd; p.slverr = slverr; p.pen = pen;
        cpl_q.push_back(p);
      end
    end
    @(posedge HCLK);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while ((sb_q.size() != 0 || bus.rsp_valid || bus.PSEL) && n < 500);
    chk("drain_sb", sb_q.size(), 0);
    @(posedge HCLK);
    #1;
  endtask

  // APB completer: plays back the planned wait states, garbage on the return lines otherwise.
  plan_t cur;
  bit    active;
  int    acc;
  initial begin
    bus.PREADY  = 1'b0;
    bus.PRDATA  = '0;
    bus.PSLVERR = 1'b0;
    active = 0;
    acc    = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        active = 0;
        continue;
      end
      if (bus.PSEL && !bus.PENABLE) begin
        if (cpl_q.size() == 0) begin
          chk("unexpected_setup", 32'h1, 32'h0);
          active = 0;
        end else begin
          cur    = cpl_q.pop_front();
          active = 1;
          acc    = 0;
          chk("setup_paddr", 32'(bus.PADDR), 32'(cur.addr));
          chk("setup_pwdata", bus.PWDATA, cur.wdata);
          chk("setup_pwrite", {31'h0, bus.PWRITE}, {31'h0, cur.wr});
        end
      end else if (bus.PSEL && bus.PENABLE && active) begin
        acc++;
        chk("access_paddr", 32'(bus.PADDR), 32'(cur.addr));
        chk("access_pwdata", bus.PWDATA, cur.wdata);
        chk("access_pwrite", {31'h0, bus.PWRITE}, {31'h0, cur.wr});
      end else if (!bus.PSEL && active) begin
        chk("penable_cycles", acc, cur.pen);
        chk("penable_low", {31'h0, bus.PENABLE}, 32'h0);
        active = 0;
      end
      if (bus.PSEL && bus.PENABLE && active) begin
        if (acc == cur.waits + 1) begin
          bus.PREADY  = 1'b1;
          bus.PRDATA  = cur.rdata;
          bus.PSLVERR = cur.slverr;
        end else begin
          bus.PREADY  = 1'b0;
          bus.PRDATA  = $urandom;
          bus.PSLVERR = 1'($urandom);
        end
      end else begin
        bus.PREADY  = 1'($urandom);
        bus.PRDATA  = $urandom;
        bus.PSLVERR = 1'($urandom);
      end
    end
  end

  // Response monitor with random backpressure.
  exp_t        e_cur;
  bit          prev_v;
  bit          prev_r;
  logic [31:0] held_rdata;
  logic        held_err;
  logic        held_tmo;
  initial begin
    bus.rsp_ready = 1'b0;
    prev_v = 0;
    prev_r = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        prev_v = 0;
        prev_r = 0;
        bus.rsp_ready = 1'b0;
        continue;
      end
      if (bus.rsp_valid) begin
        chk("req_ready_in_resp", {31'h0, bus.req_ready}, 32'h0);
        if (prev_v && !prev_r) begin
          chk("hold_rdata", bus.rsp_rdata, held_rdata);
          chk("hold_err", {31'h0, bus.rsp_err}, {31'h0, held_err});
          chk("hold_timeout", {31'h0, bus.rsp_timeout}, {31'h0, held_tmo});
        end else if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 32'h1, 32'h0);
        end else begin
          e_cur = sb_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e_cur.rdata);
          chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e_cur.err});
          chk("rsp_timeout", {31'h0, bus.rsp_timeout}, {31'h0, e_cur.tmo});
          chk("rsp_latency", cyc - e_cur.acc_cyc, e_cur.lat);
        end
        held_rdata = bus.rsp_rdata;
        held_err   = bus.rsp_err;
        held_tmo   = bus.rsp_timeout;
      end
      prev_v = bus.rsp_valid;
      if (hold_req > 0) begin
        bus.rsp_ready = 1'b0;
        if (bus.rsp_valid) hold_req--;
      end else begin
        bus.rsp_ready = ($urandom % 4 != 0);
      end
      prev_r = bus.rsp_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int            n;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    hold_req = 0;
    HRESETn  = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #3 HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    chk("rst_psel", {31'h0, bus.PSEL}, 32'h0);
    chk("rst_penable", {31'h0, bus.PENABLE}, 32'h0);
    chk("rst_pwrite", {31'h0, bus.PWRITE}, 32'h0);
    chk("rst_paddr", 32'(bus.PADDR), 32'h0);
    chk("rst_pwdata", bus.PWDATA, 32'h0);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    chk("rst_rsp_timeout", {31'h0, bus.rsp_timeout}, 32'h0);
    #2 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    @(posedge HCLK);
    #1;

    issue(1'b1, 12'h008, 32'hA5A5_0001, 0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 12'h004, 32'h0BAD_0BAD, 3, 32'h1234_5678, 1'b0, 1'b0);
    issue(1'b1, 12'h010, 32'h0000_BEEF, 1, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 12'h020, 32'h0, 10, 32'h5555_AAAA, 1'b0, 1'b0);
    issue(1'b1, 12'h024, 32'h7777_0000, 3, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 12'h006, 32'h0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      a = AW'($urandom);
      if ($urandom % 5 != 0) a[1:0] = 2'b00;
      else if (a[1:0] == 2'b00) a[1:0] = 2'b10;
      issue(1'($urandom), a, $urandom, int'($urandom_range(0, 6)), $urandom, 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge HCLK);
      #1;
    end

    drain();
    hold_req = 5;
    issue(1'b0, 12'h030, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 1'b0);
    drain();

    // Reset during ACCESS: the transfer must vanish without a response.
    issue(1'b1, 12'h040, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1'b1);
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!bus.PENABLE && n < 20);
    chk("reach_access", {31'h0, bus.PENABLE}, 32'h1);
    #2 HRESETn = 1'b0;
    #1;
    chk("midrst_psel", {31'h0, bus.PSEL}, 32'h0);
    chk("midrst_penable", {31'h0, bus.PENABLE}, 32'h0);
    chk("midrst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("midrst_paddr", 32'(bus.PADDR), 32'h0);
    chk("midrst_pwdata", bus.PWDATA, 32'h0);
    @(negedge HCLK);
    #2 HRESETn = 1'b1;
    repeat (10) @(negedge HCLK);
    chk("post_rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("post_rst_cpl_q", cpl_q.size(), 0);
    chk("post_rst_sb_q", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
